// File: rtl/aes16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes16_pkg
// Description : S-box tables, GF(2^4) arithmetic, round and key-schedule
//               helpers for the 16-bit AES-style cipher.
// Revision    : 1.0
// ============================================================================
package aes16_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXPAND  = 2'd1;
    localparam logic [1:0] ST_DECRYPT = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [3:0] SBOX [16] = '{
        4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
        4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};
    localparam logic [3:0] INV_SBOX [16] = '{
        4'hA, 4'h5, 4'h9, 4'hB, 4'h1, 4'h7, 4'h8, 4'hF,
        4'h6, 4'h0, 4'h2, 4'h3, 4'hC, 4'h4, 4'hD, 4'hE};

    // Multiply in GF(2^4) modulo x^4 + x + 1.
    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    // Round constant r is x^(r+3) placed in the upper nibble.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [3:0] p;
        p = 4'h8;
        for (int i = 0; i < 15; i++) begin
            if (i < int'(r)) p = gf4_mul(p, 4'h2);
        end
        return {p, 4'h0};
    endfunction

    function automatic logic [15:0] sub_nib(input logic [15:0] s);
        return {SBOX[s[15:12]], SBOX[s[11:8]], SBOX[s[7:4]], SBOX[s[3:0]]};
    endfunction

    function automatic logic [15:0] inv_sub_nib(input logic [15:0] s);
        return {INV_SBOX[s[15:12]], INV_SBOX[s[11:8]], INV_SBOX[s[7:4]], INV_SBOX[s[3:0]]};
    endfunction

    // Swapping nibbles 1 and 3 is its own inverse.
    function automatic logic [15:0] shift_row(input logic [15:0] s);
        return {s[15:12], s[3:0], s[7:4], s[11:8]};
    endfunction

    function automatic logic [15:0] mix_col(input logic [15:0] s);
        return {s[15:12] ^ gf4_mul(4'h4, s[11:8]), gf4_mul(4'h4, s[15:12]) ^ s[11:8],
                s[7:4] ^ gf4_mul(4'h4, s[3:0]),    gf4_mul(4'h4, s[7:4]) ^ s[3:0]};
    endfunction

    function automatic logic [15:0] inv_mix_col(input logic [15:0] s);
        return {gf4_mul(4'h9, s[15:12]) ^ gf4_mul(4'h2, s[11:8]),
                gf4_mul(4'h2, s[15:12]) ^ gf4_mul(4'h9, s[11:8]),
                gf4_mul(4'h9, s[7:4])   ^ gf4_mul(4'h2, s[3:0]),
                gf4_mul(4'h2, s[7:4])   ^ gf4_mul(4'h9, s[3:0])};
    endfunction

    // SubNib(RotNib(w)) on one key byte.
    function automatic logic [7:0] sub_rot(input logic [7:0] w);
        return {SBOX[w[3:0]], SBOX[w[7:4]]};
    endfunction

    function automatic logic [15:0] key_next(input logic [15:0] k, input logic [7:0] rc);
        logic [7:0] w2;
        w2 = k[15:8] ^ sub_rot(k[7:0]) ^ rc;
        return {w2, w2 ^ k[7:0]};
    endfunction

    function automatic logic [15:0] key_prev(input logic [15:0] k, input logic [7:0] rc);
        logic [7:0] w1;
        w1 = k[7:0] ^ k[15:8];
        return {k[15:8] ^ sub_rot(w1) ^ rc, w1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/decryption_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : decryption_iter_if
// Description : Ciphertext/key input and plaintext output handshakes.
// Revision    : 1.0
// ============================================================================
interface decryption_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] codein;
    logic [15:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] codeout;

    modport master (output in_valid, codein, key, out_ready,
                    input  in_ready, out_valid, codeout);
    modport slave  (input  in_valid, codein, key, out_ready,
                    output in_ready, out_valid, codeout);
endinterface
`default_nettype wire

// File: rtl/aes16_inv_round.sv
`default_nettype none
// ============================================================================
// Module      : aes16_inv_round
// Description : One combinational inverse round plus one inverse key step.
// Revision    : 1.0
// ============================================================================
module aes16_inv_round
    import aes16_pkg::*;
(
    input  logic [15:0] st,
    input  logic [15:0] kr,
    input  logic [7:0]  rcon,
    output logic [15:0] st_next,
    output logic [15:0] kr_prev
);
    assign st_next = inv_sub_nib(shift_row(inv_mix_col(st ^ kr)));
    assign kr_prev = key_prev(kr, rcon);
endmodule
`default_nettype wire

// File: rtl/decryption_iter.sv
`default_nettype none
// ============================================================================
// Module      : decryption_iter
// Description : Iterative 16-bit AES-style decryptor, one inverse round/clk.
//               Define KEY_CACHE_EN to skip key expansion on a repeated key.
// Revision    : 1.0
// ============================================================================
module decryption_iter
    import aes16_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic               clk,
    input  logic               rst,
    decryption_iter_if.slave   bus
);
    localparam logic [3:0] C_LAST_ROUND = 4'(NUM_ROUNDS - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_ctr;
    logic [15:0] r_st;
    logic [15:0] r_kr;
    logic [15:0] r_codeout;
    logic [7:0]  w_rcon;
    logic [15:0] w_kr_fwd;
    logic [15:0] w_st_next;
    logic [15:0] w_kr_prev;

`ifdef KEY_CACHE_EN
    logic        r_cache_valid;
    logic [15:0] r_cache_key;
    logic [15:0] r_cache_kn;
    logic [15:0] r_key_in;
    logic        w_hit;
    assign w_hit = r_cache_valid && (bus.key == r_cache_key);
`endif

    assign w_rcon   = rcon(r_ctr);
    assign w_kr_fwd = key_next(r_kr, w_rcon);

    aes16_inv_round u_round (
        .st      (r_st),
        .kr      (r_kr),
        .rcon    (w_rcon),
        .st_next (w_st_next),
        .kr_prev (w_kr_prev)
    );

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.codeout   = r_codeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ctr     <= 4'd0;
            r_st      <= 16'h0;
            r_kr      <= 16'h0;
            r_codeout <= 16'h0;
`ifdef KEY_CACHE_EN
            r_cache_valid <= 1'b0;
            r_cache_key   <= 16'h0;
            r_cache_kn    <= 16'h0;
            r_key_in      <= 16'h0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_st <= bus.codein;
`ifdef KEY_CACHE_EN
                        r_key_in <= bus.key;
                        if (w_hit) begin
                            r_kr    <= r_cache_kn;
                            r_ctr   <= C_LAST_ROUND;
                            r_state <= ST_DECRYPT;
                        end else begin
                            r_kr    <= bus.key;
                            r_ctr   <= 4'd0;
                            r_state <= ST_EXPAND;
                        end
`else
                        r_kr    <= bus.key;
                        r_ctr   <= 4'd0;
                        r_state <= ST_EXPAND;
`endif
                    end
                end
                ST_EXPAND: begin
                    r_kr <= w_kr_fwd;
                    // ctr stays at the last round so DECRYPT starts from K[NUM_ROUNDS].
                    if (r_ctr == C_LAST_ROUND) begin
                        r_state <= ST_DECRYPT;
`ifdef KEY_CACHE_EN
                        r_cache_valid <= 1'b1;
                        r_cache_key   <= r_key_in;
                        r_cache_kn    <= w_kr_fwd;
`endif
                    end else begin
                        r_ctr <= r_ctr + 4'd1;
                    end
                end
                ST_DECRYPT: begin
                    r_st <= w_st_next;
                    r_kr <= w_kr_prev;
                    if (r_ctr == 4'd0) begin
                        r_codeout <= w_st_next ^ w_kr_prev;
                        r_state   <= ST_DONE;
                    end else begin
                        r_ctr <= r_ctr - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_decryption_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_decryption_iter
// Description : Round-trip bench; ciphertexts come from a behavioural encryptor.
// Revision    : 1.0
// ============================================================================
module tb_decryption_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   sb [16] = '{9, 4, 10, 11, 13, 1, 8, 5, 6, 2, 0, 3, 12, 14, 15, 7};
    bit   c_valid = 1'b0;
    int   c_key   = 0;

    decryption_iter_if bus ();

    decryption_iter #(.NUM_ROUNDS(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Polynomial product, then reduction by x^4+x+1 (0x13).
    function automatic int gmul(int a, int b);
        int p = 0;
        for (int i = 0; i < 4; i++) if (((b >> i) & 1) != 0) p ^= a << i;
        for (int i = 6; i >= 4; i--) if (((p >> i) & 1) != 0) p ^= 'h13 << (i - 4);
        return p;
    endfunction

    function automatic int encrypt(int pt, int key);
        int k [11];
        int n [4];
        int rc, w0, w1, w2, s, a, b, t;
        k[0] = key;
        rc = 8;
        for (int r = 0; r < 10; r++) begin
            w0 = k[r] >> 8;
            w1 = k[r] & 'hFF;
            w2 = w0 ^ (rc << 4) ^ ((sb[w1 & 15] << 4) | sb[w1 >> 4]);
            k[r + 1] = (w2 << 8) | (w2 ^ w1);
            rc = gmul(rc, 2);
        end
        s = pt ^ k[0];
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 4; i++) n[i] = sb[(s >> (12 - 4 * i)) & 15];
            t = n[1]; n[1] = n[3]; n[3] = t;
            for (int c = 0; c < 4; c += 2) begin
                a = n[c]; b = n[c + 1];
                n[c]     = a ^ gmul(4, b);
                n[c + 1] = gmul(4, a) ^ b;
            end
            s = ((n[0] << 12) | (n[1] << 8) | (n[2] << 4) | n[3]) ^ k[r + 1];
        end
        return s;
    endfunction

    task automatic run_block(input int pt, input int key, input int hold, input bit early);
        int lat, exp_lat;
        exp_lat = 21;
`ifdef KEY_CACHE_EN
        if (c_valid && key == c_key) exp_lat = 11;
`endif
        c_valid = 1'b1;
        c_key   = key;
        @(negedge clk);
        check_eq("in_ready_idle", 32'(bus.in_ready), 1);
        bus.in_valid  = 1'b1;
        bus.codein    = 16'(encrypt(pt, key));
        bus.key       = 16'(key);
        bus.out_ready = early;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.codein   = 16'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            if (lat == 5) check_eq("in_ready_busy", 32'(bus.in_ready), 0);
            @(negedge clk);
            lat++;
        end
        check_eq("latency", lat, exp_lat);
        check_eq("codeout", 32'(bus.codeout), pt);
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = (h == 20);
            bus.codein   = 16'($urandom);
            bus.key      = 16'($urandom);
            @(negedge clk);
            check_eq("hold_valid", 32'(bus.out_valid), 1);
            check_eq("hold_code", 32'(bus.codeout), pt);
            check_eq("hold_ready", 32'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq("back_idle", 32'(bus.in_ready), 1);
        check_eq("valid_drop", 32'(bus.out_valid), 0);
    endtask

    task automatic abort_block(input int pt, input int key);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.codein   = 16'(encrypt(pt, key));
        bus.key      = 16'(key);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        c_valid = 1'b0;
        check_eq("rst_valid", 32'(bus.out_valid), 0);
        check_eq("rst_code", 32'(bus.codeout), 0);
        check_eq("rst_ready", 32'(bus.in_ready), 1);
    endtask

    initial begin
        int ka, kb;
        bus.in_valid  = 1'b0;
        bus.codein    = 16'h0;
        bus.key       = 16'h0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("reset_ready", 32'(bus.in_ready), 1);
        check_eq("reset_valid", 32'(bus.out_valid), 0);
        check_eq("reset_code", 32'(bus.codeout), 0);

        run_block('h6F6B, 'hA73B, 0, 1'b0);
        run_block('h0000, 'h0000, 0, 1'b0);
        run_block('hFFFF, 'hFFFF, 0, 1'b1);
        run_block('h1234, 'h5A5A, 50, 1'b0);

        ka = int'($urandom & 'hFFFF);
        kb = ka ^ 'h0101;
        run_block(int'($urandom & 'hFFFF), ka, 0, 1'b0);
        run_block(int'($urandom & 'hFFFF), ka, 0, 1'b0);
        run_block(int'($urandom & 'hFFFF), kb, 0, 1'b0);
        run_block(int'($urandom & 'hFFFF), ka, 0, 1'b0);
        abort_block(int'($urandom & 'hFFFF), ka);
        run_block(int'($urandom & 'hFFFF), ka, 0, 1'b0);

        for (int i = 0; i < 1000; i++)
            run_block(int'($urandom & 'hFFFF), int'($urandom & 'hFFFF), 0, 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
